// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffered header/payload/parity packet source for the router 1x3 input port
// Optional ROUTER_PKT_TX_PARITY_ERR_EN adds corrupt_parity to force a bad parity byte.
module router_pkt_tx #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
  input  logic       corrupt_parity,
`endif
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP} state_t;

  state_t     r_state, w_next_state;
  logic [1:0] r_addr;
  logic [5:0] r_len, r_wr_cnt, r_rd_cnt, w_rd_next;
  logic [7:0] r_parity;
  logic [3:0] r_gap_cnt;
  logic       r_corrupt;
  logic [7:0] r_buf [0:63];
  logic       r_pl_ready, r_pkt_valid, r_tx_busy, r_tx_done, r_err;
  logic [7:0] r_data_out;
  logic       w_start_ok, w_wr_en, w_accept, w_corrupt_in;
  logic [7:0] w_data_next;
  logic       w_pkt_valid_next;

`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
  assign w_corrupt_in = corrupt_parity;
`else
  assign w_corrupt_in = 1'b0;
`endif

  assign w_start_ok = (dest_addr != 2'd3) && (payload_len != 6'd0);
  assign w_wr_en    = (r_state == S_LOAD) && pl_valid;
  assign w_accept   = !busy;

  always_comb begin
    w_next_state = r_state;
    w_rd_next    = r_rd_cnt;
    case (r_state)
      S_IDLE:    if (start && w_start_ok) w_next_state = S_LOAD;
      S_LOAD:    if (w_wr_en && (r_wr_cnt == r_len - 6'd1)) w_next_state = S_HEADER;
      S_HEADER:  if (w_accept) begin
                   w_next_state = S_PAYLOAD;
                   w_rd_next    = 6'd0;
                 end
      S_PAYLOAD: if (w_accept) begin
                   if (r_rd_cnt == r_len - 6'd1) w_next_state = S_PARITY;
                   else w_rd_next = r_rd_cnt + 6'd1;
                 end
      S_PARITY:  if (w_accept) w_next_state = S_GAP;
      S_GAP:     if (r_gap_cnt == 4'(GAP_CYCLES - 1)) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the byte on data_out is registered.
  always_comb begin
    w_data_next      = 8'h00;
    w_pkt_valid_next = 1'b0;
    case (w_next_state)
      S_HEADER: begin
        w_data_next      = {r_len, r_addr};
        w_pkt_valid_next = 1'b1;
      end
      S_PAYLOAD: begin
        w_data_next      = r_buf[w_rd_next];
        w_pkt_valid_next = 1'b1;
      end
      S_PARITY: w_data_next = r_parity ^ {7'd0, r_corrupt};
      default:  ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) r_buf[r_wr_cnt] <= pl_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_addr      <= 2'd0;
      r_len       <= 6'd0;
      r_wr_cnt    <= 6'd0;
      r_rd_cnt    <= 6'd0;
      r_parity    <= 8'h00;
      r_gap_cnt   <= 4'd0;
      r_corrupt   <= 1'b0;
      r_data_out  <= 8'h00;
      r_pkt_valid <= 1'b0;
      r_pl_ready  <= 1'b0;
      r_tx_busy   <= 1'b0;
      r_tx_done   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_rd_cnt    <= w_rd_next;
      r_data_out  <= w_data_next;
      r_pkt_valid <= w_pkt_valid_next;
      r_pl_ready  <= (w_next_state == S_LOAD);
      r_tx_busy   <= (w_next_state != S_IDLE);
      r_tx_done   <= (r_state == S_PARITY) && w_accept;
      r_err       <= (r_state == S_IDLE) && start && !w_start_ok;
      case (r_state)
        S_IDLE: if (start && w_start_ok) begin
          r_addr    <= dest_addr;
          r_len     <= payload_len;
          r_parity  <= 8'h00;
          r_wr_cnt  <= 6'd0;
          r_corrupt <= w_corrupt_in;
        end
        S_LOAD: if (w_wr_en) begin
          r_wr_cnt <= r_wr_cnt + 6'd1;
          r_parity <= r_parity ^ pl_data;
        end
        S_HEADER: if (w_accept) r_parity <= r_parity ^ {r_len, r_addr};
        S_PARITY: r_gap_cnt <= 4'd0;
        S_GAP:    r_gap_cnt <= r_gap_cnt + 4'd1;
        default:  ;
      endcase
    end
  end

  assign pl_ready  = r_pl_ready;
  assign data_out  = r_data_out;
  assign pkt_valid = r_pkt_valid;
  assign tx_ready  = resetn & ~r_tx_busy;
  assign tx_done   = r_tx_done;
  assign err       = r_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - randomized self-checking bench for router_pkt_tx against a packet-level model
module tb_router_pkt_tx;
  localparam int GAP = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] payload_len = 6'd0;
  logic [7:0] pl_data = 8'h00;
  logic       pl_valid = 1'b0;
  logic       busy = 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
  logic       corrupt_parity = 1'b0;
`endif
  logic       pl_ready, pkt_valid, tx_ready, tx_done, err;
  logic [7:0] data_out;

  router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
    .clock(clock), .resetn(resetn), .start(start), .dest_addr(dest_addr),
    .payload_len(payload_len),
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
    .corrupt_parity(corrupt_parity),
`endif
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .busy(busy),
    .data_out(data_out), .pkt_valid(pkt_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .err(err)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  logic [7:0] pl_q[$], exp_b[$], obs_b[$];
  bit   obs_pv[$], busy_q[$];
  int   obs_hold[$];
  int   busy_pct = 0, gap_pct = 0, wire_cycles, gap_cycles, stall_bad, err_seen;
  bit   toggle_valid = 0, noise = 0, last_corrupt = 0;
  bit   to_flag, load_ok, ready_after, td_pv, done_after;
  logic [7:0] td_d;

  // Reference: header {len,addr}, payload in order, then XOR of everything sent.
  task automatic model(input logic [1:0] a, input logic [5:0] l);
    logic [7:0] p;
    p = {l, a};
    exp_b.delete();
    exp_b.push_back(p);
    foreach (pl_q[i]) begin
      exp_b.push_back(pl_q[i]);
      p = p ^ pl_q[i];
    end
    if (last_corrupt) p = p ^ 8'h01;
    exp_b.push_back(p);
  endtask

  task automatic do_start(input logic [1:0] a, input logic [5:0] l, input bit c);
    int k = 0;
    to_flag = 0; err_seen = 0; last_corrupt = c;
    while (!tx_ready && k < 200) begin @(posedge clock); #1; k++; end
    if (!tx_ready) to_flag = 1;
    start = 1; dest_addr = a; payload_len = l;
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
    corrupt_parity = c;
`endif
    @(posedge clock); #1;
    start = 0;
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
    corrupt_parity = 0;
`endif
    load_ok = pl_ready;
  endtask

  task automatic do_load();
    int i = 0, k = 0;
    bit ph = 0, v, take;
    while (i < pl_q.size() && k < 1000) begin
      if (toggle_valid) begin v = ph; ph = ~ph; end
      else v = ($urandom_range(0, 99) >= gap_pct);
      pl_valid = v;
      pl_data  = v ? pl_q[i] : 8'($urandom);
      if (noise) begin start = 1; dest_addr = 2'd3; end
      take = v && pl_ready;
      @(posedge clock); #1;
      if (err) err_seen++;
      if (take) i++;
      k++;
    end
    pl_valid = 0;
    if (i < pl_q.size()) to_flag = 1;
    ready_after = pl_ready;
  endtask

  task automatic do_wire();
    int k = 0, hold = 0;
    logic [7:0] prev_d = 8'h00;
    bit prev_busy = 0, prev_pv = 0;
    obs_b.delete(); obs_pv.delete(); obs_hold.delete();
    wire_cycles = 0; stall_bad = 0; done_after = 0;
    while (!tx_done && k < 600) begin
      if (prev_busy && (data_out !== prev_d || pkt_valid !== prev_pv)) stall_bad++;
      if (err) err_seen++;
      prev_d = data_out; prev_pv = pkt_valid;
      busy = (busy_q.size() > 0) ? busy_q.pop_front() : ($urandom_range(0, 99) < busy_pct);
      hold++;
      if (!busy) begin
        obs_b.push_back(data_out); obs_pv.push_back(pkt_valid); obs_hold.push_back(hold);
        hold = 0;
      end
      if (noise) begin start = 1; dest_addr = 2'd3; pl_valid = 1'($urandom); pl_data = 8'($urandom); end
      prev_busy = busy;
      wire_cycles++; k++;
      @(posedge clock); #1;
    end
    busy = 0; start = 0; pl_valid = 0;
    if (!tx_done) to_flag = 1;
    td_pv = pkt_valid; td_d = data_out;
    gap_cycles = 0; k = 0;
    while (!tx_ready && k < 100) begin
      gap_cycles++; k++;
      @(posedge clock); #1;
      if (gap_cycles == 1) done_after = tx_done;
      if (err) err_seen++;
    end
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({pl_ready, data_out, pkt_valid, tx_ready, tx_done, err} !== 13'd0) begin
      n_fail++; $display("FAIL reset_outputs got %b exp 0", {pl_ready, data_out, pkt_valid, tx_ready, tx_done, err});
    end
    resetn = 1; #1;
    n_chk++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
    @(posedge clock); #1;
    n_chk++;
    if ({tx_ready, pl_ready, pkt_valid, err} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_idle got %b exp 1000", {tx_ready, pl_ready, pkt_valid, err});
    end
  endtask

  task automatic test_basic();
    pl_q = {8'hA1, 8'hB2, 8'hC3};
    busy_pct = 0; gap_pct = 0;
    do_start(2'd1, 6'd3, 0); do_load(); do_wire();
    exp_b = {8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    n_chk++;
    if (obs_b.size() != 5) begin n_fail++; $display("FAIL basic_len got %0d exp 5", obs_b.size()); end
    for (int i = 0; i < 5 && i < obs_b.size(); i++) begin
      n_chk++;
      if (obs_b[i] !== exp_b[i] || obs_pv[i] !== (i < 4)) begin
        n_fail++; $display("FAIL basic_byte%0d got %02h/%0b exp %02h/%0b", i, obs_b[i], obs_pv[i], exp_b[i], i < 4);
      end
    end
    n_chk++;
    if (wire_cycles != 5) begin n_fail++; $display("FAIL basic_wire_time got %0d exp 5", wire_cycles); end
    n_chk++;
    if ({to_flag, load_ok, ready_after} !== 3'b010) begin
      n_fail++; $display("FAIL basic_load got to/ld/rdy %b exp 010", {to_flag, load_ok, ready_after});
    end
    n_chk++;
    if ({td_pv, td_d, done_after} !== 10'd0) begin
      n_fail++; $display("FAIL basic_done got pv %b d %02h after %b exp 0 00 0", td_pv, td_d, done_after);
    end
    n_chk++;
    if (gap_cycles != GAP) begin n_fail++; $display("FAIL basic_gap got %0d exp %0d", gap_cycles, GAP); end
  endtask

  task automatic test_stall();
    int exp_h[5] = '{3, 1, 2, 1, 1};
    pl_q = {8'hA1, 8'hB2, 8'hC3};
    busy_q = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_start(2'd1, 6'd3, 0); do_load(); do_wire();
    model(2'd1, 6'd3);
    n_chk++;
    if (obs_b.size() != 5 || to_flag) begin n_fail++; $display("FAIL stall_len got %0d exp 5", obs_b.size()); end
    for (int i = 0; i < 5 && i < obs_b.size(); i++) begin
      n_chk++;
      if (obs_b[i] !== exp_b[i] || obs_hold[i] != exp_h[i]) begin
        n_fail++; $display("FAIL stall_byte%0d got %02h x%0d exp %02h x%0d", i, obs_b[i], obs_hold[i], exp_b[i], exp_h[i]);
      end
    end
    n_chk++;
    if (stall_bad != 0) begin n_fail++; $display("FAIL stall_stable got %0d changes exp 0", stall_bad); end
  endtask

  task automatic test_illegal();
    logic [1:0] a[2] = '{2'd3, 2'd0};
    logic [5:0] l[2] = '{6'd5, 6'd0};
    for (int t = 0; t < 2; t++) begin
      start = 1; dest_addr = a[t]; payload_len = l[t];
      @(posedge clock); #1;
      start = 0;
      n_chk++;
      if ({err, tx_ready, pl_ready, pkt_valid} !== 4'b1100) begin
        n_fail++; $display("FAIL illegal%0d_pulse got %b exp 1100", t, {err, tx_ready, pl_ready, pkt_valid});
      end
      @(posedge clock); #1;
      n_chk++;
      if ({err, tx_ready, pl_ready, pkt_valid} !== 4'b0100) begin
        n_fail++; $display("FAIL illegal%0d_after got %b exp 0100", t, {err, tx_ready, pl_ready, pkt_valid});
      end
    end
  endtask

  task automatic test_max_len();
    pl_q.delete();
    for (int i = 0; i < 63; i++) pl_q.push_back(8'(i));
    toggle_valid = 1;
    do_start(2'd2, 6'd63, 0); do_load(); do_wire();
    toggle_valid = 0;
    model(2'd2, 6'd63);
    n_chk++;
    if (obs_b.size() != 65 || to_flag || ready_after !== 1'b0) begin
      n_fail++; $display("FAIL max_len got %0d bytes to %b rdy %b exp 65 0 0", obs_b.size(), to_flag, ready_after);
    end
    n_chk++;
    if (exp_b[0] !== 8'hFE || obs_b[0] !== 8'hFE) begin n_fail++; $display("FAIL max_header got %02h exp FE", obs_b[0]); end
    for (int i = 1; i < 65 && i < obs_b.size(); i++) begin
      n_chk++;
      if (obs_b[i] !== exp_b[i] || obs_pv[i] !== (i < 64)) begin
        n_fail++; $display("FAIL max_byte%0d got %02h/%0b exp %02h/%0b", i, obs_b[i], obs_pv[i], exp_b[i], i < 64);
      end
    end
  endtask

  task automatic test_reset_mid();
    pl_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_start(2'd1, 6'd5, 0); do_load();
    repeat (3) begin @(posedge clock); #1; end
    n_chk++;
    if (data_out !== 8'h33 || pkt_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre got %02h/%b exp 33/1", data_out, pkt_valid);
    end
    #2 resetn = 0; #1;
    n_chk++;
    if ({pkt_valid, data_out, pl_ready, tx_done} !== 11'd0) begin
      n_fail++; $display("FAIL rstmid_async got %b exp 0", {pkt_valid, data_out, pl_ready, tx_done});
    end
    @(posedge clock); #1; resetn = 1; #1;
    n_chk++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", tx_ready); end
    pl_q = {8'h55};
    do_start(2'd0, 6'd1, 0); do_load(); do_wire();
    exp_b = {8'h04, 8'h55, 8'h51};
    n_chk++;
    if (obs_b.size() != 3 || to_flag) begin n_fail++; $display("FAIL rstmid_len got %0d exp 3", obs_b.size()); end
    for (int i = 0; i < 3 && i < obs_b.size(); i++) begin
      n_chk++;
      if (obs_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL rstmid_byte%0d got %02h exp %02h", i, obs_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_random();
    logic [1:0] a;
    logic [5:0] l;
    busy_pct = 30; gap_pct = 30; noise = 1;
    for (int p = 0; p < 6; p++) begin
      a = 2'($urandom_range(0, 2));
      l = (p == 0) ? 6'd1 : (p == 1) ? 6'd63 : 6'($urandom_range(1, 62));
      pl_q.delete();
      for (int i = 0; i < l; i++) pl_q.push_back(8'($urandom));
      do_start(a, l, 0); do_load(); do_wire();
      model(a, l);
      n_chk++;
      if (obs_b.size() != exp_b.size() || to_flag) begin
        n_fail++; $display("FAIL rand%0d_len got %0d exp %0d", p, obs_b.size(), exp_b.size());
      end
      for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
        n_chk++;
        if (obs_b[i] !== exp_b[i] || obs_pv[i] !== (i < exp_b.size() - 1)) begin
          n_fail++; $display("FAIL rand%0d_byte%0d got %02h/%0b exp %02h", p, i, obs_b[i], obs_pv[i], exp_b[i]);
        end
      end
      n_chk++;
      if (stall_bad != 0 || err_seen != 0 || gap_cycles != GAP) begin
        n_fail++; $display("FAIL rand%0d_ctl got stall %0d err %0d gap %0d exp 0 0 %0d", p, stall_bad, err_seen, gap_cycles, GAP);
      end
    end
    busy_pct = 0; gap_pct = 0; noise = 0;
  endtask

`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
  task automatic test_corrupt();
    logic [7:0] par[2] = '{8'hDC, 8'hDD};
    for (int t = 0; t < 2; t++) begin
      pl_q = {8'hA1, 8'hB2, 8'hC3};
      do_start(2'd1, 6'd3, (t == 0)); do_load(); do_wire();
      model(2'd1, 6'd3);
      n_chk++;
      if (obs_b.size() != 5 || obs_b[4] !== par[t] || exp_b[4] !== par[t]) begin
        n_fail++; $display("FAIL corrupt%0d_parity got %02h exp %02h", t, obs_b[obs_b.size() - 1], par[t]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_illegal();
    test_max_len();
    test_reset_mid();
    test_random();
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
    test_corrupt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
